// File: rtl/wb_write_sequencer_if.sv
// Bundle of the sequencer's result handshakes, register file write port and hazard-check signals.
// master: the sequencer side; slave: the pipeline / register file side.
interface wb_write_sequencer_if #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned AW    = 5,
    parameter int unsigned DW    = 32
);
    localparam int unsigned CW = $clog2(DEPTH) + 1;

    logic          WB_alu_valid;
    logic          WB_alu_ready;
    logic [AW-1:0] WB_alu_rd;
    logic [DW-1:0] WB_alu_data;
    logic          WB_mem_valid;
    logic          WB_mem_ready;
    logic [AW-1:0] WB_mem_rd;
    logic [DW-1:0] WB_mem_data;
    logic [AW-1:0] REG_address_wr;
    logic [DW-1:0] REG_data_wb_in1;
    logic          REG_write_1;
    logic [AW-1:0] WB_chk_addr1;
    logic [AW-1:0] WB_chk_addr2;
    logic          WB_pending1;
    logic          WB_pending2;
    logic [CW-1:0] WB_count;
    logic          WB_empty;

    modport master (
        input  WB_alu_valid, WB_alu_rd, WB_alu_data,
        input  WB_mem_valid, WB_mem_rd, WB_mem_data,
        input  WB_chk_addr1, WB_chk_addr2,
        output WB_alu_ready, WB_mem_ready,
        output REG_address_wr, REG_data_wb_in1, REG_write_1,
        output WB_pending1, WB_pending2, WB_count, WB_empty
    );

    modport slave (
        output WB_alu_valid, WB_alu_rd, WB_alu_data,
        output WB_mem_valid, WB_mem_rd, WB_mem_data,
        output WB_chk_addr1, WB_chk_addr2,
        input  WB_alu_ready, WB_mem_ready,
        input  REG_address_wr, REG_data_wb_in1, REG_write_1,
        input  WB_pending1, WB_pending2, WB_count, WB_empty
    );
endinterface

// File: rtl/wb_write_sequencer.sv
// Writeback sequencer: queues ALU/load results in order and replays each to the register file
// as a one-cycle address/data setup followed by a one-cycle write strobe.
module wb_write_sequencer #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned AW    = 5,
    parameter int unsigned DW    = 32
) (
    input logic                  clk,
    input logic                  rst_n,
    wb_write_sequencer_if.master wb_io
);
    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = PW + 1;

    typedef enum logic [1:0] {StIdle, StSetup, StStrobe} state_e;

    state_e          state_q, state_d;
    logic [PW-1:0]   rptr_q, rptr_d;
    logic [PW-1:0]   wptr_q, wptr_d;
    logic [CW-1:0]   count_q, count_d;
    logic [DEPTH-1:0] valid_q, valid_d;
    logic [AW-1:0]   rd_mem_q  [DEPTH];
    logic [DW-1:0]   dat_mem_q [DEPTH];
    logic [AW-1:0]   addr_q, addr_d;
    logic [DW-1:0]   wdata_q, wdata_d;
    logic            wr_q, wr_d;

    logic            full;
    logic            mem_ready, alu_ready;
    logic            mem_fire, alu_fire;
    logic            push, pop;
    logic [AW-1:0]   in_rd;
    logic [DW-1:0]   in_data;
    logic [PW-1:0]   rptr_inc;
    logic            pend1, pend2;

    // Accept side: MEM wins, one entry per cycle, rd == 0 is swallowed.
    always_comb begin
        full      = (count_q == CW'(DEPTH));
        mem_ready = !full;
        alu_ready = !full && !wb_io.WB_mem_valid;
        mem_fire  = wb_io.WB_mem_valid && mem_ready;
        alu_fire  = wb_io.WB_alu_valid && alu_ready;
        in_rd     = mem_fire ? wb_io.WB_mem_rd : wb_io.WB_alu_rd;
        in_data   = mem_fire ? wb_io.WB_mem_data : wb_io.WB_alu_data;
        push      = (mem_fire || alu_fire) && (in_rd != '0);
        pop       = (state_q == StStrobe);
        rptr_inc  = rptr_q + PW'(1);
    end

    always_comb begin
        wptr_d  = push ? wptr_q + PW'(1) : wptr_q;
        rptr_d  = pop ? rptr_inc : rptr_q;
        count_d = count_q + CW'(push) - CW'(pop);
        valid_d = valid_q;
        if (pop) begin
            valid_d[rptr_q] = 1'b0;
        end
        if (push) begin
            valid_d[wptr_q] = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rptr_q  <= '0;
            wptr_q  <= '0;
            count_q <= '0;
            valid_q <= '0;
        end else begin
            rptr_q  <= rptr_d;
            wptr_q  <= wptr_d;
            count_q <= count_d;
            valid_q <= valid_d;
        end
    end

    // Entry storage needs no reset; valid_q qualifies every read.
    always_ff @(posedge clk) begin
        if (push) begin
            rd_mem_q[wptr_q]  <= in_rd;
            dat_mem_q[wptr_q] <= in_data;
        end
    end

    // FSM state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next state
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:   state_d = (count_q != '0) ? StSetup : StIdle;
            StSetup:  state_d = StStrobe;
            StStrobe: state_d = (count_d != '0) ? StSetup : StIdle;
            default:  state_d = StIdle;
        endcase
    end

    // FSM outputs: address/data load on entry to SETUP, strobe tracks STROBE.
    always_comb begin
        addr_d  = addr_q;
        wdata_d = wdata_q;
        wr_d    = (state_d == StStrobe);
        if (state_d == StSetup) begin
            if (state_q != StStrobe) begin
                addr_d  = rd_mem_q[rptr_q];
                wdata_d = dat_mem_q[rptr_q];
            end else if (count_q > CW'(1)) begin
                addr_d  = rd_mem_q[rptr_inc];
                wdata_d = dat_mem_q[rptr_inc];
            end else begin
                // Only remaining entry is the one being pushed this cycle.
                addr_d  = in_rd;
                wdata_d = in_data;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            addr_q  <= '0;
            wdata_q <= '0;
            wr_q    <= 1'b0;
        end else begin
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            wr_q    <= wr_d;
        end
    end

    always_comb begin
        pend1 = 1'b0;
        pend2 = 1'b0;
        for (int i = 0; i < int'(DEPTH); i++) begin
            if (valid_q[PW'(i)] && (rd_mem_q[PW'(i)] == wb_io.WB_chk_addr1)) begin
                pend1 = 1'b1;
            end
            if (valid_q[PW'(i)] && (rd_mem_q[PW'(i)] == wb_io.WB_chk_addr2)) begin
                pend2 = 1'b1;
            end
        end
        pend1 = pend1 && (wb_io.WB_chk_addr1 != '0);
        pend2 = pend2 && (wb_io.WB_chk_addr2 != '0);
    end

    assign wb_io.WB_mem_ready    = mem_ready;
    assign wb_io.WB_alu_ready    = alu_ready;
    assign wb_io.REG_address_wr  = addr_q;
    assign wb_io.REG_data_wb_in1 = wdata_q;
    assign wb_io.REG_write_1     = wr_q;
    assign wb_io.WB_pending1     = pend1;
    assign wb_io.WB_pending2     = pend2;
    assign wb_io.WB_count        = count_q;
    assign wb_io.WB_empty        = (count_q == '0);

endmodule

// File: tb/tb_wb_write_sequencer.sv
// Directed bench for wb_write_sequencer: latency, priority, fill/wrap, rd==0, hazard flags
// and asynchronous reset during a strobe.
module tb_wb_write_sequencer;
    localparam int unsigned DEPTH = 4;
    localparam int unsigned AW    = 5;
    localparam int unsigned DW    = 32;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    wb_write_sequencer_if #(.DEPTH(DEPTH), .AW(AW), .DW(DW)) bus ();

    wb_write_sequencer #(.DEPTH(DEPTH), .AW(AW), .DW(DW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .wb_io (bus)
    );

    int n_checks = 0;
    int n_errors = 0;
    logic [AW-1:0] sa[$];
    logic [DW-1:0] sd[$];

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Advance one cycle and log any strobe seen.
    task automatic tick_rec();
        tick();
        if (bus.REG_write_1) begin
            sa.push_back(bus.REG_address_wr);
            sd.push_back(bus.REG_data_wb_in1);
        end
    endtask

    initial begin
        int k;
        int cyc;
        int n_str;
        logic acc;
        logic saw_full;
        logic [DW-1:0] last_data;

        bus.WB_alu_valid = 1'b0;
        bus.WB_alu_rd    = '0;
        bus.WB_alu_data  = '0;
        bus.WB_mem_valid = 1'b0;
        bus.WB_mem_rd    = '0;
        bus.WB_mem_data  = '0;
        bus.WB_chk_addr1 = '0;
        bus.WB_chk_addr2 = '0;

        // Reset values
        #3;
        check_eq("rst_count", bus.WB_count, 0);
        check_eq("rst_empty", bus.WB_empty, 1);
        check_eq("rst_mem_rdy", bus.WB_mem_ready, 1);
        check_eq("rst_alu_rdy", bus.WB_alu_ready, 1);
        check_eq("rst_wr", bus.REG_write_1, 0);
        check_eq("rst_addr", bus.REG_address_wr, 0);
        check_eq("rst_data", bus.REG_data_wb_in1, 0);
        #9 rst_n = 1'b1;
        tick();

        // Single ALU write: setup at E1, strobe at E2, pop at E3
        bus.WB_alu_valid = 1'b1;
        bus.WB_alu_rd    = 5'd3;
        bus.WB_alu_data  = 32'hDEADBEEF;
        bus.WB_chk_addr1 = 5'd3;
        bus.WB_chk_addr2 = 5'd4;
        #1;
        check_eq("t1_alu_rdy", bus.WB_alu_ready, 1);
        check_eq("t1_pend_pre", bus.WB_pending1, 0);
        tick();
        bus.WB_alu_valid = 1'b0;
        check_eq("t1_e0_count", bus.WB_count, 1);
        check_eq("t1_e0_pend1", bus.WB_pending1, 1);
        check_eq("t1_e0_pend2", bus.WB_pending2, 0);
        check_eq("t1_e0_wr", bus.REG_write_1, 0);
        tick();
        check_eq("t1_e1_addr", bus.REG_address_wr, 3);
        check_eq("t1_e1_data", bus.REG_data_wb_in1, 32'hDEADBEEF);
        check_eq("t1_e1_wr", bus.REG_write_1, 0);
        tick();
        check_eq("t1_e2_wr", bus.REG_write_1, 1);
        check_eq("t1_e2_addr", bus.REG_address_wr, 3);
        check_eq("t1_e2_data", bus.REG_data_wb_in1, 32'hDEADBEEF);
        check_eq("t1_e2_pend1", bus.WB_pending1, 1);
        tick();
        check_eq("t1_e3_wr", bus.REG_write_1, 0);
        check_eq("t1_e3_count", bus.WB_count, 0);
        check_eq("t1_e3_empty", bus.WB_empty, 1);
        check_eq("t1_e3_pend1", bus.WB_pending1, 0);
        check_eq("t1_e3_addr_hold", bus.REG_address_wr, 3);

        // ALU and MEM together: MEM first
        bus.WB_mem_valid = 1'b1;
        bus.WB_mem_rd    = 5'd6;
        bus.WB_mem_data  = 32'h66;
        bus.WB_alu_valid = 1'b1;
        bus.WB_alu_rd    = 5'd5;
        bus.WB_alu_data  = 32'h55;
        #1;
        check_eq("t2_alu_rdy_blk", bus.WB_alu_ready, 0);
        check_eq("t2_mem_rdy", bus.WB_mem_ready, 1);
        tick();
        bus.WB_mem_valid = 1'b0;
        #1;
        check_eq("t2_count1", bus.WB_count, 1);
        check_eq("t2_alu_rdy", bus.WB_alu_ready, 1);
        tick();
        bus.WB_alu_valid = 1'b0;
        check_eq("t2_count2", bus.WB_count, 2);
        sa.delete();
        sd.delete();
        repeat (10) tick_rec();
        check_eq("t2_nstrobes", sa.size(), 2);
        if (sa.size() == 2) begin
            check_eq("t2_first_addr", sa[0], 6);
            check_eq("t2_first_data", sd[0], 32'h66);
            check_eq("t2_second_addr", sa[1], 5);
            check_eq("t2_second_data", sd[1], 32'h55);
        end

        // Continuous stream of 10 entries: fill, stall, wrap
        sa.delete();
        sd.delete();
        k = 1;
        cyc = 0;
        saw_full = 1'b0;
        while (k <= 10 && cyc < 200) begin
            bus.WB_alu_valid = 1'b1;
            bus.WB_alu_rd    = AW'(k);
            bus.WB_alu_data  = DW'(k);
            #1;
            acc = bus.WB_alu_ready;
            tick_rec();
            cyc++;
            if (acc) k++;
            if (bus.WB_count == 4) begin
                saw_full = 1'b1;
                check_eq("t3_full_mem_rdy", bus.WB_mem_ready, 0);
                check_eq("t3_full_alu_rdy", bus.WB_alu_ready, 0);
            end
        end
        bus.WB_alu_valid = 1'b0;
        check_eq("t3_accepted", k, 11);
        check_eq("t3_saw_full", saw_full, 1);
        repeat (30) tick_rec();
        check_eq("t3_nstrobes", sa.size(), 10);
        for (int i = 0; i < sa.size() && i < 10; i++) begin
            check_eq("t3_addr", sa[i], i + 1);
            check_eq("t3_data", sd[i], i + 1);
        end
        check_eq("t3_empty", bus.WB_empty, 1);

        // rd == 0 is accepted and dropped
        sa.delete();
        bus.WB_chk_addr1 = '0;
        bus.WB_alu_valid = 1'b1;
        bus.WB_alu_rd    = '0;
        bus.WB_alu_data  = 32'h1234;
        #1;
        check_eq("t4_alu_rdy", bus.WB_alu_ready, 1);
        tick_rec();
        bus.WB_alu_valid = 1'b0;
        check_eq("t4_count", bus.WB_count, 0);
        check_eq("t4_pend0", bus.WB_pending1, 0);
        repeat (6) tick_rec();
        check_eq("t4_nstrobes", sa.size(), 0);

        // Two writes to rd 7: pending held until the second strobe completes
        bus.WB_chk_addr2 = 5'd7;
        bus.WB_alu_valid = 1'b1;
        bus.WB_alu_rd    = 5'd7;
        bus.WB_alu_data  = 32'hA1;
        tick();
        bus.WB_alu_data  = 32'hB2;
        tick();
        bus.WB_alu_valid = 1'b0;
        check_eq("t5_count", bus.WB_count, 2);
        n_str = 0;
        last_data = '0;
        repeat (8) begin
            check_eq("t5_pend2", bus.WB_pending2, (n_str < 2) ? 1 : 0);
            if (bus.REG_write_1) begin
                n_str++;
                last_data = bus.REG_data_wb_in1;
            end
            tick();
        end
        check_eq("t5_nstrobes", n_str, 2);
        check_eq("t5_final_data", last_data, 32'hB2);

        // Reset asserted while strobing with 3 entries queued
        sa.delete();
        bus.WB_alu_valid = 1'b1;
        for (int i = 1; i <= 3; i++) begin
            bus.WB_alu_rd   = AW'(i + 10);
            bus.WB_alu_data = DW'(i);
            tick();
        end
        bus.WB_alu_valid = 1'b0;
        check_eq("t6_pre_wr", bus.REG_write_1, 1);
        check_eq("t6_pre_count", bus.WB_count, 3);
        rst_n = 1'b0;
        #1;
        check_eq("t6_wr_drop", bus.REG_write_1, 0);
        check_eq("t6_count", bus.WB_count, 0);
        check_eq("t6_empty", bus.WB_empty, 1);
        check_eq("t6_alu_rdy", bus.WB_alu_ready, 1);
        check_eq("t6_addr", bus.REG_address_wr, 0);
        #2 rst_n = 1'b1;
        repeat (12) tick_rec();
        check_eq("t6_nstrobes", sa.size(), 0);
        check_eq("t6_count_after", bus.WB_count, 0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

    // Hard timeout so the run always ends.
    initial begin
        #200000;
        $display("FAIL timeout got=running exp=finished");
        $fatal(1);
    end
endmodule

// File: doc/wb_write_sequencer.md
# wb_write_sequencer

Writeback sequencer that drives the register file's write port. It accepts completed results from the ALU and memory paths over valid/ready handshakes, buffers them in a small in-order queue, and replays each one to the register file as a setup-then-strobe sequence. The register file latches data on the rising edge of its write strobe, so the sequencer holds address and data stable for one full cycle before raising the strobe. It also reports pending writes so decode can stall on read-after-write hazards.

## Interface
- DEPTH, 4, queue entries (power of two, ≥2)
- AW, 5, register address width
- DW, 32, data width
---
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous, active-low reset
- WB_alu_valid / WB_alu_ready  in / out  1  ALU result handshake
- WB_alu_rd  in  AW  ALU destination register
- WB_alu_data  in  DW  ALU result
- WB_mem_valid / WB_mem_ready  in / out  1  load result handshake
- WB_mem_rd  in  AW  load destination register
- WB_mem_data  in  DW  load result
- REG_address_wr  out  AW  register file write address (registered)
- REG_data_wb_in1  out  DW  register file write data (registered)
- REG_write_1  out  1  register file write strobe (registered)
- WB_chk_addr1, WB_chk_addr2  in  AW  decode source registers to check
- WB_pending1, WB_pending2  out  1  a write to that source is queued or in flight
- WB_count  out  $clog2(DEPTH)+1  queued entries, including the in-flight head
- WB_empty  out  1  WB_count == 0

## Operation
- Handshakes complete when valid and ready are both high on a rising clk edge.
- MEM has priority over ALU. At most one entry is accepted per cycle.
  - WB_mem_ready = !full
  - WB_alu_ready = !full && !WB_mem_valid
- There is no pass-through when full, even if a pop happens in the same cycle.
- A result with rd == 0 is accepted (handshake completes) but discarded. It is not enqueued and the count does not change.
- The queue is a circular FIFO.
  - Read and write pointers wrap modulo DEPTH.
  - Push and pop in the same cycle leave the count unchanged.
- FSM states:
  - IDLE: strobe 0. Go to SETUP when the queue is non-empty.
  - SETUP: load the head entry's rd and data into REG_address_wr / REG_data_wb_in1. Strobe 0. Go to STROBE next cycle.
  - STROBE: REG_write_1 = 1, address and data unchanged. On exit, pop the head. Go to SETUP if another entry remains after the pop, else IDLE.
- Sustained throughput is one register write per 2 cycles.
- REG_address_wr and REG_data_wb_in1 hold their last values in IDLE.
- Pending flags:
  - WB_pendingN = 1 if WB_chk_addrN is non-zero and matches the rd of any valid queue entry, including the head during SETUP/STROBE.
  - Combinational from the current queue state. A same-cycle incoming handshake is not included.
- Reset, asynchronous on rst_n low:
  - Queue emptied, pointers 0, FSM to IDLE.
  - REG_address_wr = 0, REG_data_wb_in1 = 0, REG_write_1 = 0.
  - WB_count = 0, WB_empty = 1, both ready outputs = 1.
  - Reset mid-STROBE drops the strobe immediately and discards all entries.

## Timing
- Entry accepted at edge E0:
  - FSM leaves IDLE at E1 (SETUP, address/data valid from E1).
  - REG_write_1 rises at E2.
  - REG_write_1 falls and the entry pops at E3.
- WB_count increments after E0 and decrements after E3.
- Back-to-back entries: the strobe is high every other cycle, with address/data changing only on SETUP edges.
- Pending clears for a register in the cycle after its STROBE, unless a younger entry targets the same register.

## Test plan
- Reset, then single ALU write rd=3, data=0xDEADBEEF:
  - Strobe rises exactly 2 cycles after the handshake.
  - REG_address_wr=3 and REG_data_wb_in1=0xDEADBEEF are stable from the SETUP edge through the strobe.
  - WB_pending1 is high while WB_chk_addr1=3 and the write is queued.
- ALU and MEM valid together (rd=5 and rd=6):
  - MEM is accepted first, WB_alu_ready=0 that cycle.
  - ALU is accepted next cycle.
  - Strobes occur in the order 6 then 5.
- Fill to DEPTH=4 with the FSM stalled behind a continuous stream:
  - Both readies are 0 at count 4.
  - Accept resumes after a pop.
  - Pointers wrap correctly over 10 entries with data 1..10, written in order.
- Write with rd=0, data=0x1234:
  - Handshake completes, WB_count stays 0, no strobe.
  - WB_pending for address 0 is never set.
- Two queued writes to rd=7:
  - WB_pending stays high until the second strobe completes.
  - The final value is the younger entry's data.
- rst_n pulsed low while REG_write_1=1 with 3 entries queued:
  - Strobe drops asynchronously.
  - WB_count=0, WB_empty=1.
  - No further strobes after release.
